game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 164 ++++++++++++++++
 tb/tb_game_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - snake game sequencer: state FSM, tick divider, 2-deep direction queue.
// Optional pause support is compiled in with `define PAUSE_EN.
module game_sequencer #(
    parameter int TICK_DIV = 10600000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] kb_dir,
    input  logic [3:0] btn_dir,
    input  logic       lose,
    input  logic       win,
    output logic [2:0] state,
    output logic       tick,
    output logic       restart,
    output logic [1:0] dir
);

    localparam logic [26:0] DIV_LAST = 27'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PLAY   = 3'd1,
        S_PAUSED = 3'd2,
        S_OVER   = 3'd3,
        S_WON    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [26:0] div_q, div_d;
    logic        tick_q, tick_d;
    logic        restart_q, restart_d;
    logic [1:0]  dir_q, dir_d;
    logic [1:0]  q0_q, q0_d, q1_q, q1_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        start_q;
    logic [3:0]  kb_q, btn_q;

    logic        start_edge, pause_edge;
    logic [3:0]  kb_e, btn_e;
    logic        kb_ok, btn_ok, cand_v, push, pop;
    logic [1:0]  cand, ref_dir, tail;

`ifdef PAUSE_EN
    logic pause_q;
    assign pause_edge = pause & ~pause_q;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign pause_edge   = 1'b0;
`endif

    // Key bit map (up,left,right,down) to head code (right=0,down=1,left=2,up=3)
    function automatic logic [1:0] code_of(input logic [3:0] b);
        case (b)
            4'b0001: code_of = 2'd3;
            4'b0010: code_of = 2'd2;
            4'b0100: code_of = 2'd0;
            default: code_of = 2'd1;
        endcase
    endfunction

    assign start_edge = start & ~start_q;
    assign kb_e       = kb_dir & ~kb_q;
    assign btn_e      = btn_dir & ~btn_q;
    assign kb_ok      = $onehot(kb_e);
    assign btn_ok     = $onehot(btn_e);
    assign cand       = kb_ok ? code_of(kb_e) : code_of(btn_e);
    assign cand_v     = (state_q == S_PLAY) && (kb_ok || btn_ok);
    assign tail       = (cnt_q == 2'd2) ? q1_q : q0_q;
    assign ref_dir    = (cnt_q != 2'd0) ? tail : dir_q;
    // Same axis (bit 0 equal) means either identical or a reversal
    assign push       = cand_v && (cand[0] != ref_dir[0]) && (cnt_q != 2'd2);
    assign pop        = tick_q && (cnt_q != 2'd0);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        dir_d     = dir_q;
        q0_d      = q0_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        restart_d = 1'b0;

        if (pop) dir_d = q0_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) q0_d = cand;
                else               q1_d = cand;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                q0_d  = q1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11:   q0_d = cand;
            default: ;
        endcase

        case (state_q)
            S_PLAY: begin
                if (lose)            state_d = S_OVER;
                else if (win)        state_d = S_WON;
                else if (pause_edge) state_d = S_PAUSED;
                else                 div_d   = (div_q == DIV_LAST) ? 27'd0 : div_q + 27'd1;
            end
            S_PAUSED: begin
                if (!start_edge && pause_edge) state_d = S_PLAY;
            end
            default: ;
        endcase

        if (state_q != S_PLAY && start_edge) begin
            state_d   = S_PLAY;
            restart_d = 1'b1;
            div_d     = 27'd0;
            dir_d     = 2'd0;
            cnt_d     = 2'd0;
        end

        tick_d = (state_d == S_PLAY) && (div_d == DIV_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            div_q     <= 27'd0;
            tick_q    <= 1'b0;
            restart_q <= 1'b0;
            dir_q     <= 2'd0;
            q0_q      <= 2'd0;
            q1_q      <= 2'd0;
            cnt_q     <= 2'd0;
            start_q   <= 1'b0;
            kb_q      <= 4'd0;
            btn_q     <= 4'd0;
`ifdef PAUSE_EN
            pause_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
            restart_q <= restart_d;
            dir_q     <= dir_d;
            q0_q      <= q0_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            start_q   <= start;
            kb_q      <= kb_dir;
            btn_q     <= btn_dir;
`ifdef PAUSE_EN
            pause_q   <= pause;
`endif
        end
    end

    assign state   = state_q;
    assign tick    = tick_q;
    assign restart = restart_q;
    assign dir     = dir_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer with TICK_DIV=4.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, pause, lose, win;
    logic [3:0] kb_dir, btn_dir;
    logic [2:0] state;
    logic       tick, restart;
    logic [1:0] dir;
    int         n_checks = 0;
    int         n_fail = 0;

    game_sequencer #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause),
        .kb_dir(kb_dir), .btn_dir(btn_dir), .lose(lose), .win(win),
        .state(state), .tick(tick), .restart(restart), .dir(dir)
    );

    always #5 clk = ~clk;

    task automatic hard_reset();
        rst = 1'b0; start = 1'b0; pause = 1'b0; lose = 1'b0; win = 1'b0;
        kb_dir = 4'd0; btn_dir = 4'd0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic go_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; pause = 1'b0; lose = 1'b0; win = 1'b0;
        kb_dir = 4'd0; btn_dir = 4'd0;
        @(negedge clk);
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", state); end
        n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick: got %b want 0", tick); end
        n_checks++; if (restart !== 1'b0) begin n_fail++; $display("FAIL rst_restart: got %b want 0", restart); end
        n_checks++; if (dir !== 2'd0) begin n_fail++; $display("FAIL rst_dir: got %0d want 0", dir); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL idle_hold: got %0d want 0", state); end
    endtask

    task automatic test_start_tick();
        hard_reset();
        go_start();
        n_checks++; if (restart !== 1'b1) begin n_fail++; $display("FAIL start_restart: got %b want 1", restart); end
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL start_state: got %0d want 1", state); end
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (tick !== ((i == 4 || i == 8) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL tick_cadence cyc%0d: got %b want %b", i, tick, (i == 4 || i == 8));
            end
            n_checks++; if (restart !== 1'b0) begin n_fail++; $display("FAIL restart_len cyc%0d: got %b want 0", i, restart); end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (restart !== 1'b0) begin n_fail++; $display("FAIL start_in_play: got %b want 0", restart); end
        repeat (3) @(negedge clk);
        n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL tick_after_ignored_start: got %b want 1", tick); end
    endtask

    task automatic test_queue_opposite();
        hard_reset();
        go_start();
        kb_dir = 4'b0001;
        @(negedge clk);
        kb_dir = 4'b0000; btn_dir = 4'b1000;
        @(negedge clk);
        btn_dir = 4'b0000;
        @(negedge clk);
        n_checks++; if (tick !== 1'b1 || dir !== 2'd0) begin n_fail++; $display("FAIL q_pre_tick: tick %b dir %0d want 1/0", tick, dir); end
        @(negedge clk);
        n_checks++; if (dir !== 2'd3) begin n_fail++; $display("FAIL q_tick1_dir: got %0d want 3", dir); end
        repeat (4) @(negedge clk);
        n_checks++; if (dir !== 2'd3) begin n_fail++; $display("FAIL q_tick2_dir: got %0d want 3", dir); end
    endtask

    task automatic test_arbitration();
        hard_reset();
        go_start();
        kb_dir = 4'b0100; btn_dir = 4'b0010;
        @(negedge clk);
        kb_dir = 4'b0000; btn_dir = 4'b0000;
        repeat (3) @(negedge clk);
        n_checks++; if (dir !== 2'd0) begin n_fail++; $display("FAIL arb_tick1_dir: got %0d want 0", dir); end
        repeat (4) @(negedge clk);
        n_checks++; if (dir !== 2'd0) begin n_fail++; $display("FAIL arb_tick2_dir: got %0d want 0", dir); end
    endtask

    task automatic test_multibit();
        hard_reset();
        go_start();
        kb_dir = 4'b1001;
        @(negedge clk);
        kb_dir = 4'b0000; btn_dir = 4'b1001;
        @(negedge clk);
        btn_dir = 4'b0000;
        repeat (2) @(negedge clk);
        n_checks++; if (dir !== 2'd0) begin n_fail++; $display("FAIL multibit_dir: got %0d want 0", dir); end
    endtask

    task automatic test_queue_full();
        hard_reset();
        go_start();
        kb_dir = 4'b1000;
        @(negedge clk);
        kb_dir = 4'b0010;
        @(negedge clk);
        kb_dir = 4'b0001;
        @(negedge clk);
        kb_dir = 4'b0000;
        @(negedge clk);
        n_checks++; if (dir !== 2'd1) begin n_fail++; $display("FAIL full_tick1_dir: got %0d want 1", dir); end
        repeat (4) @(negedge clk);
        n_checks++; if (dir !== 2'd2) begin n_fail++; $display("FAIL full_tick2_dir: got %0d want 2", dir); end
        repeat (4) @(negedge clk);
        n_checks++; if (dir !== 2'd2) begin n_fail++; $display("FAIL full_drop_dir: got %0d want 2", dir); end
    endtask

    task automatic test_end_states();
        hard_reset();
        go_start();
        kb_dir = 4'b1000;
        @(negedge clk);
        kb_dir = 4'b0000;
        repeat (3) @(negedge clk);
        n_checks++; if (dir !== 2'd1) begin n_fail++; $display("FAIL end_setup_dir: got %0d want 1", dir); end
        lose = 1'b1; win = 1'b1;
        @(negedge clk);
        lose = 1'b0; win = 1'b0;
        n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL lose_priority: got %0d want 3", state); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (tick !== 1'b0 || state !== 3'd3) begin
                n_fail++; $display("FAIL over_frozen cyc%0d: tick %b state %0d want 0/3", i, tick, state);
            end
        end
        go_start();
        n_checks++; if (restart !== 1'b1 || state !== 3'd1 || dir !== 2'd0) begin
            n_fail++; $display("FAIL over_restart: restart %b state %0d dir %0d want 1/1/0", restart, state, dir);
        end
        win = 1'b1;
        @(negedge clk);
        win = 1'b0;
        n_checks++; if (state !== 3'd4) begin n_fail++; $display("FAIL win_state: got %0d want 4", state); end
        go_start();
        n_checks++; if (restart !== 1'b1 || state !== 3'd1) begin
            n_fail++; $display("FAIL won_restart: restart %b state %0d want 1/1", restart, state);
        end
    endtask

    task automatic test_pause();
        hard_reset();
        go_start();
        repeat (2) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
`ifdef PAUSE_EN
        n_checks++; if (state !== 3'd2 || tick !== 1'b0) begin
            n_fail++; $display("FAIL pause_enter: state %0d tick %b want 2/0", state, tick);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (state !== 3'd2 || tick !== 1'b0) begin
                n_fail++; $display("FAIL pause_hold cyc%0d: state %0d tick %b want 2/0", i, state, tick);
            end
        end
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        n_checks++; if (state !== 3'd1 || tick !== 1'b0) begin
            n_fail++; $display("FAIL pause_resume: state %0d tick %b want 1/0", state, tick);
        end
        @(negedge clk);
        n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL pause_resume_tick: got %b want 1", tick); end
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        @(negedge clk);
        n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL pause_again: got %0d want 2", state); end
        start = 1'b1; pause = 1'b1;
        @(negedge clk);
        start = 1'b0; pause = 1'b0;
        n_checks++; if (state !== 3'd1 || restart !== 1'b1) begin
            n_fail++; $display("FAIL start_over_pause: state %0d restart %b want 1/1", state, restart);
        end
`else
        n_checks++; if (state !== 3'd1 || tick !== 1'b1) begin
            n_fail++; $display("FAIL pause_ignored: state %0d tick %b want 1/1", state, tick);
        end
        @(negedge clk);
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL pause_ignored_state: got %0d want 1", state); end
`endif
    endtask

    task automatic test_reset_mid();
        hard_reset();
        go_start();
        repeat (3) @(negedge clk);
        n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL mid_pre_tick: got %b want 1", tick); end
        kb_dir = 4'b0001;
        rst = 1'b0;
        #1;
        n_checks++; if (tick !== 1'b0 || restart !== 1'b0 || state !== 3'd0 || dir !== 2'd0) begin
            n_fail++; $display("FAIL async_reset: tick %b restart %b state %0d dir %0d want 0/0/0/0", tick, restart, state, dir);
        end
        @(negedge clk);
        rst = 1'b1; kb_dir = 4'b0000;
        @(negedge clk);
        n_checks++; if (tick !== 1'b0 || restart !== 1'b0 || state !== 3'd0) begin
            n_fail++; $display("FAIL post_reset: tick %b restart %b state %0d want 0/0/0", tick, restart, state);
        end
        go_start();
        repeat (4) @(negedge clk);
        n_checks++; if (dir !== 2'd0) begin n_fail++; $display("FAIL post_reset_queue: got %0d want 0", dir); end
    endtask

    initial begin
        test_reset();
        test_start_tick();
        test_queue_opposite();
        test_arbitration();
        test_multibit();
        test_queue_full();
        test_end_states();
        test_pause();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
